// File: rtl/synth_pkg.sv
// synth_pkg: shared widths, the rest encoding and tone FSM states for the synth blocks
package synth_pkg;
  localparam int PERIOD_W = 16;
  localparam logic [PERIOD_W-1:0] REST_PERIOD = 16'd0;
  typedef enum logic {SILENT, PLAY} tone_state_t;
endpackage

// File: rtl/note_tone_gen_half_period_counter.sv
// half_period_counter: counts clk50 cycles within one half-period and pulses wrap on its last cycle
module half_period_counter
  import synth_pkg::*;
#(
  parameter int W = PERIOD_W
) (
  input  logic         clk50,
  input  logic         reset,
  input  logic         load,
  input  logic         run,
  input  logic [W-1:0] period,
  output logic         wrap,
  output logic [W-1:0] cnt
);
  assign wrap = run && (cnt == period - 1'b1);
  // restart on load or at the end of each half, otherwise advance while running
  always_ff @(posedge clk50)
    cnt <= (reset || load || wrap) ? '0 : run ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/note_tone_gen.sv
// note_tone_gen: glitch-free square-wave tone from a half-period note word; optional TONE_OCTAVE_EN adds oct_up
module note_tone_gen
  import synth_pkg::*;
#(
  parameter int                  PERIOD_W   = synth_pkg::PERIOD_W,
  parameter logic [PERIOD_W-1:0] MIN_PERIOD = 16'd16
) (
  input  logic                clk50,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] note_period,
  input  logic                enable,
`ifdef TONE_OCTAVE_EN
  input  logic [1:0]          oct_up,
`endif
  output logic                tone_out,
  output logic                tone_active,
  output logic                note_start,
  output logic [PERIOD_W-1:0] period_cur
);
  tone_state_t         state;
  logic [PERIOD_W-1:0] eff;
  logic [PERIOD_W-1:0] cnt;
  logic                valid;
  logic                wrap;
`ifdef TONE_OCTAVE_EN
  assign eff = note_period >> oct_up;
`else
  assign eff = note_period;
`endif
  assign valid = enable && (eff >= MIN_PERIOD);
  half_period_counter #(.W(PERIOD_W)) u_cnt (
    .clk50  (clk50),
    .reset  (reset),
    .load   (state == SILENT && valid),
    .run    (state == PLAY),
    .period (period_cur),
    .wrap   (wrap),
    .cnt    (cnt)
  );
  // start on a valid request; toggle at each half end; resample the request only at the end of the low half
  always_ff @(posedge clk50) begin
    if (reset) begin
      state       <= SILENT;
      tone_out    <= 1'b0;
      tone_active <= 1'b0;
      note_start  <= 1'b0;
      period_cur  <= REST_PERIOD;
    end else begin
      note_start <= 1'b0;
      if (state == SILENT) begin
        if (valid) begin
          state       <= PLAY;
          period_cur  <= eff;
          tone_out    <= 1'b1;
          tone_active <= 1'b1;
          note_start  <= 1'b1;
        end
      end else if (wrap) begin
        if (tone_out) tone_out <= 1'b0;
        else if (!valid) begin
          state       <= SILENT;
          tone_active <= 1'b0;
          period_cur  <= REST_PERIOD;
        end else begin
          tone_out <= 1'b1;
          if (eff != period_cur) begin
            period_cur <= eff;
            note_start <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: scoreboard bench for note_tone_gen against a full-period phase model
module tb_note_tone_gen;
  typedef struct {
    logic        out;
    logic        act;
    logic        st;
    logic [15:0] pc;
  } exp_t;
  localparam int MINP = 16;
  logic        clk50 = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] note_period = 16'd0;
  logic        tone_out, tone_active, note_start;
  logic [15:0] period_cur;
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          m_act = 0;
  int          m_p = 0;
  int          m_t = 0;
  bit          m_st = 0;
  note_tone_gen #(.MIN_PERIOD(16'd16)) dut (
    .clk50       (clk50),
    .reset       (reset),
    .note_period (note_period),
    .enable      (enable),
`ifdef TONE_OCTAVE_EN
    .oct_up      (2'd0),
`endif
    .tone_out    (tone_out),
    .tone_active (tone_active),
    .note_start  (note_start),
    .period_cur  (period_cur)
  );
  always #10 clk50 = ~clk50;
  function automatic void model(input bit r, input bit e, input int np);
    bit ok;
    ok = e && np >= MINP;
    m_st = 0;
    if (r) begin
      m_act = 0; m_p = 0; m_t = 0;
    end else if (!m_act) begin
      if (ok) begin m_act = 1; m_p = np; m_t = 0; m_st = 1; end
    end else if (m_t == 2 * m_p - 1) begin
      if (!ok) begin m_act = 0; m_p = 0; m_t = 0; end
      else begin
        if (np != m_p) begin m_p = np; m_st = 1; end
        m_t = 0;
      end
    end else m_t++;
  endfunction
  task automatic step(input bit r, input bit e, input int np, input int n = 1);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      @(negedge clk50);
      reset = r; enable = e; note_period = 16'(np);
      model(r, e, np);
      x.out = m_act && m_t < m_p;
      x.act = m_act;
      x.st  = m_st;
      x.pc  = 16'(m_p);
      q.push_back(x);
    end
  endtask
  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", nm, cyc, a, e);
    end
  endtask
  // monitor: pop one expectation per clock and compare just after the edge
  initial forever begin
    exp_t x;
    @(posedge clk50);
    #1;
    cyc++;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("tone_out", {15'd0, tone_out}, {15'd0, x.out});
      chk("tone_active", {15'd0, tone_active}, {15'd0, x.act});
      chk("note_start", {15'd0, note_start}, {15'd0, x.st});
      chk("period_cur", period_cur, x.pc);
    end
  end
  initial begin
    int np, en, wd;
    step(1, 0, 0, 2);
    step(0, 1, 100, 130);
    step(0, 1, 50, 300);
    step(0, 1, 0, 250);
    step(0, 1, 100, 120);
    step(0, 0, 100, 250);
    step(0, 1, 8, 60);
    step(0, 1, 100, 40);
    step(1, 1, 100, 1);
    step(0, 1, 100, 30);
    step(0, 1, 0, 10);
    step(0, 1, 100, 500);
    step(0, 1, 16, 100);
    step(0, 1, 15, 100);
    np = 20; en = 1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 40) == 0) np = $urandom_range(0, 40);
      if ($urandom_range(0, 150) == 0) en = ~en & 1;
      step($urandom_range(0, 700) == 0, en[0], np);
    end
    wd = 0;
    while (q.size() > 0 && wd < 100) begin
      @(posedge clk50);
      wd++;
    end
    #2;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
